// File: rtl/aes_dec_scheduler.sv
// Request arbiter / job sequencer in front of an iterative AES decipher engine.
// Define AES_SCHED_RR_EN for round-robin arbitration; the default build is fixed priority (req0 wins).
module aes_dec_scheduler #(
  parameter int TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         keylen,
  input  logic         key_we,
  input  logic [3:0]   key_addr,
  input  logic [127:0] key_wdata,
  output logic         key_wr_drop,
  output logic         eng_next,
  output logic         eng_keylen,
  output logic [127:0] eng_block,
  output logic [127:0] eng_round_key,
  input  logic [3:0]   eng_round,
  input  logic [127:0] eng_new_block,
  input  logic         eng_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_block,
  output logic         rsp_src,
  output logic         rsp_err
);

  // state | meaning
  // IDLE  | waiting for a request; only state that grants or accepts key writes
  // ISSUE | one-cycle eng_next pulse to start the engine
  // BUSY  | engine running; timeout counter advancing
  // RESP  | result presented until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state_q, state_d;
  logic [127:0]   blk_q;
  logic           src_q;
  logic           keylen_q;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   key_tab [15];
  logic           grant, grant_src, key_ok, timeout_hit;
  logic [3:0]     nr;

`ifdef AES_SCHED_RR_EN
  logic ptr_q;

  // ptr_q names the requester that wins a tie
  always_comb begin
    grant_src = 1'b0;
    if (req0_valid && req1_valid) grant_src = ptr_q;
    else                          grant_src = req1_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= 1'b0;
    else if (grant) ptr_q <= ~grant_src;
  end
`else
  assign grant_src = ~req0_valid;
`endif

  assign grant       = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready  = grant && !grant_src;
  assign req1_ready  = grant && grant_src;
  assign key_ok      = key_we && !rst && (state_q == S_IDLE) && !grant && (key_addr <= 4'd14);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  assign eng_next   = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_RESP);
  assign eng_block  = blk_q;
  assign eng_keylen = keylen_q;
  assign nr         = keylen_q ? 4'd14 : 4'd10;

  // Decryption walks the table backwards; out-of-range rounds fall back to entry 0
  always_comb begin
    eng_round_key = key_tab[0];
    if (eng_round <= nr) eng_round_key = key_tab[nr - eng_round];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_BUSY;
      S_BUSY:  if (eng_ready || timeout_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      src_q       <= 1'b0;
      keylen_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_block   <= '0;
      rsp_src     <= 1'b0;
      rsp_err     <= 1'b0;
      key_wr_drop <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_wr_drop <= key_we && !key_ok;
      if (grant) begin
        blk_q    <= grant_src ? req1_block : req0_block;
        src_q    <= grant_src;
        keylen_q <= keylen;
      end
      if (state_q == S_BUSY) begin
        if (eng_ready) begin
          rsp_block <= eng_new_block;
          rsp_err   <= 1'b0;
          rsp_src   <= src_q;
          cnt_q     <= '0;
        end else if (timeout_hit) begin
          rsp_block <= '0;
          rsp_err   <= 1'b1;
          rsp_src   <= src_q;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // Key table survives reset so firmware need not reload it
  always_ff @(posedge clk) begin
    if (key_ok) key_tab[key_addr] <= key_wdata;
  end

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Scoreboard bench for aes_dec_scheduler with a behavioural AES-128 inverse-cipher engine.
module tb_aes_dec_scheduler;
  localparam int TIMEOUT = 31;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_block, req1_block;
  logic keylen, key_we, key_wr_drop;
  logic [3:0] key_addr;
  logic [127:0] key_wdata;
  logic eng_next, eng_keylen, eng_ready;
  logic [127:0] eng_block, eng_round_key, eng_new_block;
  logic [3:0] eng_round;
  logic rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [127:0] rsp_block;

  aes_dec_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block),
    .keylen(keylen), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .key_wr_drop(key_wr_drop),
    .eng_next(eng_next), .eng_keylen(eng_keylen), .eng_block(eng_block),
    .eng_round_key(eng_round_key), .eng_round(eng_round), .eng_new_block(eng_new_block),
    .eng_ready(eng_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_block(rsp_block),
    .rsp_src(rsp_src), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {logic [127:0] blk; logic src; logic err;} exp_t;
  exp_t sb[$];
  int grants[$];
  logic [127:0] rk [11];
  logic [7:0] inv_sb [256];
  int eng_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic push_exp(input logic [127:0] blk, input logic src, input logic err);
    exp_t e;
    e.blk = blk; e.src = src; e.err = err;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    if (x == 8'h00) v = 8'h00;
    else for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] key,
                                             input bit first, input bit last);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    int s;
    if (first) return st ^ key;
    for (int i = 0; i < 16; i++) begin
      s = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      t[127-8*i -: 8] = inv_sb[st[127-8*s -: 8]];
    end
    t ^= key;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
        t[127-32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
    end
    return t;
  endfunction

  // Engine model: one round per cycle, starting in the cycle eng_next is seen
  initial begin : engine
    bit busy;
    int r, nr;
    logic [127:0] st;
    busy = 0; r = 0; nr = 10; st = '0;
    eng_ready = 1'b0; eng_round = 4'd0; eng_new_block = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        eng_ready = 1'b0;
      end else begin
        eng_ready = 1'b0;
        if (!busy && eng_next && eng_mode == 0) begin
          busy = 1; r = 0; nr = eng_keylen ? 14 : 10; st = eng_block;
        end
        if (busy) begin
          eng_round = 4'(r);
          #1;
          st = inv_round(st, eng_round_key, r == 0, r == nr);
          r++;
          if (r > nr) begin
            busy = 0;
            eng_new_block = st;
            eng_ready = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        timeout_fail("rsp_unexpected");
      end else begin
        e = sb.pop_front();
        check("rsp_block", rsp_block, e.blk);
        check("rsp_src", rsp_src, e.src);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
    end
  end

  task automatic write_key(input logic [3:0] addr, input logic [127:0] data, input bit chk);
    key_we = 1'b1; key_addr = addr; key_wdata = data;
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    if (chk) check("key_wr_drop_accepted", key_wr_drop, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      timeout_fail(name);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_jobs(input int n0, input int n1);
    int c0, c1, budget;
    c0 = n0; c1 = n1; budget = 3000;
    req0_block = CT; req1_block = CT;
    while ((c0 > 0 || c1 > 0) && budget > 0) begin
      req0_valid = (c0 > 0); req1_valid = (c1 > 0);
      @(negedge clk);
      if (req0_ready) begin push_exp(PT, 1'b0, 1'b0); c0--; end
      if (req1_ready) begin push_exp(PT, 1'b1, 1'b0); c1--; end
      @(posedge clk); #1;
      budget--;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (budget == 0) timeout_fail("run_jobs_grant");
    wait_drain("run_jobs_drain");
  endtask

  task automatic start_req0(input logic [127:0] exp_blk, input logic exp_err, output int t_grant);
    req0_block = CT; req0_valid = 1'b1; t_grant = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        t_grant = cyc;
        push_exp(exp_blk, 1'b0, exp_err);
        break;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    if (t_grant < 0) timeout_fail("grant0_wait");
  endtask

  task automatic wait_eng_next(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (eng_next) begin t = cyc; break; end
    end
    if (t < 0) timeout_fail("eng_next_wait");
  endtask

  task automatic wait_rsp_valid(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin t = cyc; break; end
    end
    if (t < 0) timeout_fail("rsp_valid_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w [44];
    logic [31:0] t;
    logic [127:0] kv;
    logic [7:0] rc;
    int tg, ti, tr;

    kv = KEY; rc = 8'h01;
    for (int i = 0; i < 256; i++) inv_sb[sbox(8'(i))] = 8'(i);
    for (int i = 0; i < 4; i++) w[i] = kv[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; req0_block = CT; req1_block = CT;
    keylen = 1'b0; key_we = 1'b0; key_addr = 4'd0; key_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req0_ready", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_eng_next", eng_next, 0);
    check("reset_key_wr_drop", key_wr_drop, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_block", rsp_block, 0);
    check("reset_rsp_src", rsp_src, 0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;

    for (int k = 0; k < 11; k++) write_key(4'(k), rk[k], k == 10);

    // Table lookup: eng_round r reads entry 10-r, beyond NR reads entry 0
    eng_round = 4'd0;  #1 check("lookup_r0", eng_round_key, rk[10]);
    eng_round = 4'd3;  #1 check("lookup_r3", eng_round_key, rk[7]);
    eng_round = 4'd10; #1 check("lookup_r10", eng_round_key, rk[0]);
    eng_round = 4'd11; #1 check("lookup_r11", eng_round_key, rk[0]);
    eng_round = 4'd15; #1 check("lookup_r15", eng_round_key, rk[0]);
    @(posedge clk); #1;

    run_jobs(1, 0);

    // Engine silent: timeout response
    eng_mode = 1;
    start_req0(128'h0, 1'b1, tg);
    wait_eng_next(ti);
    check("grant_to_next_latency", ti - tg, 1);
    wait_rsp_valid(tr);
    check("timeout_latency", tr - ti, TIMEOUT + 1);
    wait_drain("timeout_drain");
    eng_mode = 0;

    // Response stall: outputs hold, no grant, no eng_next
    rsp_ready = 1'b0;
    start_req0(PT, 1'b0, tg);
    req1_valid = 1'b1;
    wait_rsp_valid(tr);
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_block", rsp_block, PT);
      check("stall_rsp_src", rsp_src, 0);
      check("stall_rsp_err", rsp_err, 0);
      check("stall_no_grant", req1_ready, 0);
      check("stall_eng_next", eng_next, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req1_valid = 1'b0;
    wait_drain("stall_drain");

    // Rejected key writes: during BUSY, out-of-range address, and colliding with a grant
    start_req0(PT, 1'b0, tg);
    wait_eng_next(ti);
    @(posedge clk); #1;
    key_we = 1'b1; key_addr = 4'd0; key_wdata = '1;
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    check("drop_busy", key_wr_drop, 1);
    @(negedge clk);
    check("drop_pulse_width", key_wr_drop, 0);
    wait_drain("drop_busy_drain");
    key_we = 1'b1; key_addr = 4'd15; key_wdata = '1;
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    check("drop_addr15", key_wr_drop, 1);
    @(posedge clk); #1;
    req0_block = CT; req0_valid = 1'b1;
    key_we = 1'b1; key_addr = 4'd0; key_wdata = '1;
    @(negedge clk);
    check("collide_grant", req0_ready, 1);
    if (req0_ready) push_exp(PT, 1'b0, 1'b0);
    @(posedge clk); #1;
    key_we = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    check("drop_collide", key_wr_drop, 1);
    wait_drain("collide_drain");
    run_jobs(0, 1);

    // Reset in BUSY: job abandoned, outputs back to reset values
    start_req0(PT, 1'b0, tg);
    wait_eng_next(ti);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_eng_next", eng_next, 0);
    check("rst_mid_rsp_block", rsp_block, 0);
    check("rst_mid_rsp_src", rsp_src, 0);
    check("rst_mid_rsp_err", rsp_err, 0);
    check("rst_mid_eng_block", eng_block, 0);
    @(posedge clk); #1;

    // Arbitration order with both requesters loaded
    grants.delete();
    run_jobs(3, 3);
    check("grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
`ifdef AES_SCHED_RR_EN
      check($sformatf("grant_order_%0d", i), grants[i], i % 2);
`else
      check($sformatf("grant_order_%0d", i), grants[i], (i >= 3) ? 1 : 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
